// File: rtl/bitsim_pkg.sv
// Shared types and constants for the bit-serial sparse-bit scheduler.
package bitsim_pkg;

  localparam int NUM_CAND     = 3;
  localparam int WEIGHT_WIDTH = 8;
  localparam int PLANE_W      = $clog2(WEIGHT_WIDTH);

  typedef logic [1:0]         cand_sel_t;
  typedef logic [PLANE_W-1:0] plane_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/bit_sel_scheduler_if.sv
// Weight-triple input channel and beat output channel of the scheduler.
//
// Handshake rule for both channels: a transfer happens on a rising clock edge
// where valid and ready are both 1. The producer holds valid and its payload
// stable until that edge; ready may depend combinationally on the other side.
interface bit_sel_scheduler_if
  import bitsim_pkg::*;
#(
  parameter int WEIGHT_WIDTH = bitsim_pkg::WEIGHT_WIDTH
);
  localparam int PLANE_W = $clog2(WEIGHT_WIDTH);

  logic                    in_valid;
  logic                    in_ready;
  logic [WEIGHT_WIDTH-1:0] in_weight [NUM_CAND];

  logic                    out_valid;
  logic                    out_ready;
  cand_sel_t               sel;
  logic                    val;
  logic [PLANE_W-1:0]      plane;
  logic                    last;

  // Environment side: weight source plus beat consumer.
  modport master (
    output in_valid, in_weight, out_ready,
    input  in_ready, out_valid, sel, val, plane, last
  );

  // Scheduler side.
  modport slave (
    input  in_valid, in_weight, out_ready,
    output in_ready, out_valid, sel, val, plane, last
  );

endinterface

// File: rtl/bit_sel_scheduler_plane_pri_enc.sv
// Picks the next pending bit: highest nonzero plane, lowest candidate within it.
// Also reports whether any bit is pending and whether exactly one is.
module plane_pri_enc
  import bitsim_pkg::*;
#(
  parameter int WEIGHT_WIDTH = bitsim_pkg::WEIGHT_WIDTH,
  parameter int PLANE_W      = $clog2(WEIGHT_WIDTH)
) (
  input  logic [WEIGHT_WIDTH-1:0] m [NUM_CAND],
  output logic [PLANE_W-1:0]      p,
  output cand_sel_t               i,
  output logic                    any,
  output logic                    single
);

  logic [WEIGHT_WIDTH-1:0] plane_any;
  logic                    seen;
  logic                    multi;

  always_comb begin
    plane_any = '0;
    for (int b = 0; b < WEIGHT_WIDTH; b++) begin
      for (int c = 0; c < NUM_CAND; c++) begin
        plane_any[b] = plane_any[b] | m[c][b];
      end
    end
  end

  // Ascending scan so the highest set plane wins.
  always_comb begin
    p   = '0;
    any = 1'b0;
    for (int b = 0; b < WEIGHT_WIDTH; b++) begin
      if (plane_any[b]) begin
        p   = PLANE_W'(b);
        any = 1'b1;
      end
    end
  end

  // Descending scan so the lowest candidate index wins.
  always_comb begin
    i = '0;
    for (int c = NUM_CAND - 1; c >= 0; c--) begin
      if (m[c][p]) begin
        i = cand_sel_t'(c);
      end
    end
  end

  always_comb begin
    seen  = 1'b0;
    multi = 1'b0;
    for (int c = 0; c < NUM_CAND; c++) begin
      for (int b = 0; b < WEIGHT_WIDTH; b++) begin
        if (m[c][b]) begin
          if (seen) begin
            multi = 1'b1;
          end
          seen = 1'b1;
        end
      end
    end
    single = seen & ~multi;
  end

endmodule

// File: rtl/bit_sel_scheduler.sv
// Emits one mux-select beat per set weight bit, MSB plane first; an all-zero
// triple yields a single beat with val = 0.
module bit_sel_scheduler
  import bitsim_pkg::*;
#(
  parameter int WEIGHT_WIDTH = bitsim_pkg::WEIGHT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  bit_sel_scheduler_if.slave   bus,
  output state_t               dbg_state
);

  localparam int PLANE_W = $clog2(WEIGHT_WIDTH);

  state_t                  state_q;
  state_t                  state_n;
  logic [WEIGHT_WIDTH-1:0] m_q   [NUM_CAND];
  logic [WEIGHT_WIDTH-1:0] m_clr [NUM_CAND];
  logic                    zero_q;

  logic [PLANE_W-1:0]      enc_p;
  cand_sel_t               enc_i;
  logic                    enc_any;
  logic                    enc_single;

  logic                    busy;
  logic                    beat_last;
  logic                    fire_out;
  logic                    load;
  logic                    in_zero;

  plane_pri_enc #(
    .WEIGHT_WIDTH (WEIGHT_WIDTH),
    .PLANE_W      (PLANE_W)
  ) u_enc (
    .m      (m_q),
    .p      (enc_p),
    .i      (enc_i),
    .any    (enc_any),
    .single (enc_single)
  );

  assign busy      = (state_q == RUN);
  assign beat_last = zero_q | enc_single;
  assign fire_out  = busy & bus.out_ready;
  // Accepting on the last handshake lets triples flow back-to-back.
  assign bus.in_ready = !busy || (fire_out && beat_last);
  assign load      = bus.in_valid & bus.in_ready;
  assign dbg_state = state_q;

  always_comb begin
    in_zero = 1'b1;
    for (int c = 0; c < NUM_CAND; c++) begin
      if (|bus.in_weight[c]) begin
        in_zero = 1'b0;
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CAND; c++) begin
      m_clr[c] = m_q[c];
      if (!zero_q && enc_any && (cand_sel_t'(c) == enc_i)) begin
        m_clr[c][enc_p] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CAND; c++) begin
        m_q[c] <= '0;
      end
      zero_q <= 1'b0;
    end else if (load) begin
      for (int c = 0; c < NUM_CAND; c++) begin
        m_q[c] <= bus.in_weight[c];
      end
      zero_q <= in_zero;
    end else if (fire_out) begin
      for (int c = 0; c < NUM_CAND; c++) begin
        m_q[c] <= m_clr[c];
      end
      zero_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE: if (load) state_n = RUN;
      RUN:  if (fire_out && beat_last && !load) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Beat fields read only registered state, so nothing from in_* reaches out_*.
  always_comb begin
    bus.out_valid = busy;
    bus.sel       = '0;
    bus.plane     = '0;
    bus.val       = 1'b0;
    bus.last      = 1'b0;
    if (busy) begin
      if (zero_q) begin
        bus.last = 1'b1;
      end else begin
        bus.sel   = enc_i;
        bus.plane = enc_p;
        bus.val   = 1'b1;
        bus.last  = enc_single;
      end
    end
  end

endmodule

// File: tb/tb_bit_sel_scheduler.sv
// Directed bench for bit_sel_scheduler: beat order, zero triples, stalls,
// back-to-back loads and mid-group reset.
module tb_bit_sel_scheduler;
  import bitsim_pkg::*;

  logic   clk;
  logic   reset;
  state_t dbg_state;

  int checks   = 0;
  int failures = 0;

  // Expected beats packed as {val, last, sel[1:0], plane[2:0]}.
  logic [6:0] exp_q [$];

  bit_sel_scheduler_if #(.WEIGHT_WIDTH(8)) bus ();

  bit_sel_scheduler #(.WEIGHT_WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] beat(input logic v, input logic l, input logic [1:0] s,
                                      input logic [2:0] p);
    return {v, l, s, p};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    bus.out_ready    = 1'b0;
    bus.in_valid     = 1'b1;
    bus.in_weight[0] = a;
    bus.in_weight[1] = b;
    bus.in_weight[2] = c;
    #1;
    chk("load_in_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic run_beats(input int n, input bit stall);
    int         got = 0;
    int         cyc = 0;
    logic [6:0] obs;
    logic [6:0] exp;
    logic [6:0] held = '0;
    bit         have_held = 1'b0;
    while (got < n && cyc < 400) begin
      bus.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      obs = {bus.val, bus.last, bus.sel, bus.plane};
      if (have_held) begin
        chk("stall_hold", obs, held);
      end
      have_held = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        exp = exp_q.pop_front();
        chk("beat", obs, exp);
        chk("in_ready_on_last", bus.in_ready, exp[5]);
        got++;
      end else if (bus.out_valid) begin
        held      = obs;
        have_held = 1'b1;
      end else begin
        chk("out_valid_pending", bus.out_valid, 1);
      end
      tick();
      cyc++;
    end
    bus.out_ready = 1'b0;
    chk("beat_count", got, n);
  endtask

  task automatic chk_idle(input string tag);
    #1;
    chk({tag, "_state"}, dbg_state, IDLE);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
  endtask

  initial begin
    reset            = 1'b1;
    bus.in_valid     = 1'b0;
    bus.out_ready    = 1'b0;
    bus.in_weight[0] = '0;
    bus.in_weight[1] = '0;
    bus.in_weight[2] = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_fields", {bus.val, bus.last, bus.sel, bus.plane}, 0);
    chk("rst_state", dbg_state, IDLE);
    reset = 1'b0;
    tick();
    chk("post_rst_in_ready", bus.in_ready, 1);

    // Sparse triple: two plane-7 bits then one plane-0 bit.
    load(8'b1000_0001, 8'b1000_0000, 8'h00);
    chk("latency_out_valid", bus.out_valid, 1);
    exp_q.push_back(beat(1, 0, 2'd0, 3'd7));
    exp_q.push_back(beat(1, 0, 2'd1, 3'd7));
    exp_q.push_back(beat(1, 1, 2'd0, 3'd0));
    run_beats(3, 1'b0);
    chk_idle("t1_end");

    // All-zero triple: one beat with val = 0.
    load(8'h00, 8'h00, 8'h00);
    exp_q.push_back(beat(0, 1, 2'd0, 3'd0));
    run_beats(1, 1'b0);
    chk_idle("t2_end");

    // Full triple under random stalls: 24 beats, last only on the final one.
    load(8'hFF, 8'hFF, 8'hFF);
    for (int p = 7; p >= 0; p--) begin
      for (int c = 0; c < 3; c++) begin
        exp_q.push_back(beat(1, (p == 0 && c == 2), 2'(c), 3'(p)));
      end
    end
    run_beats(24, 1'b1);
    chk_idle("t3_end");

    // Back-to-back: second triple loads on the first triple's last handshake.
    bus.in_valid     = 1'b1;
    bus.in_weight[0] = 8'h03;
    bus.in_weight[1] = 8'h00;
    bus.in_weight[2] = 8'h00;
    tick();
    bus.in_weight[0] = 8'h00;
    bus.in_weight[2] = 8'h01;
    bus.out_ready    = 1'b1;
    #1;
    chk("b2b_beat0", {bus.val, bus.last, bus.sel, bus.plane}, beat(1, 0, 2'd0, 3'd1));
    chk("b2b_busy_in_ready", bus.in_ready, 0);
    tick();
    #1;
    chk("b2b_beat1", {bus.val, bus.last, bus.sel, bus.plane}, beat(1, 1, 2'd0, 3'd0));
    chk("b2b_last_in_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("b2b_no_bubble", bus.out_valid, 1);
    chk("b2b_second", {bus.val, bus.last, bus.sel, bus.plane}, beat(1, 1, 2'd2, 3'd0));
    chk("b2b_state", dbg_state, RUN);
    tick();
    bus.out_ready = 1'b0;
    chk_idle("t4_end");

    // Reset after 2 of 5 beats discards the rest.
    load(8'hF0, 8'h01, 8'h00);
    exp_q.push_back(beat(1, 0, 2'd0, 3'd7));
    exp_q.push_back(beat(1, 0, 2'd0, 3'd6));
    run_beats(2, 1'b0);
    chk("pre_rst_out_valid", bus.out_valid, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_fields", {bus.val, bus.last, bus.sel, bus.plane}, 0);
    tick();
    reset = 1'b0;
    tick();
    chk_idle("t5_after_rst");
    load(8'h10, 8'h00, 8'h00);
    exp_q.push_back(beat(1, 1, 2'd0, 3'd4));
    run_beats(1, 1'b0);
    chk_idle("t5_end");
    chk("exp_q_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
